apb4_master_bridge: RTL and testbench
=====================================

Name: apb4_master_bridge

Overview:
Simple valid/ready command-to-APB4 initiator. It accepts one read or write command, runs a single APB4 transfer (SETUP then ACCESS, with wait states), and returns data and status on a valid/ready response channel. It drives peripheral slaves such as the timer from CPU-side or DMA-side logic, and it includes a bus timeout so a hung slave cannot stall the requester.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr_i and paddr_o.
DATA_WIDTH, 32, data width. Must be a multiple of 8.
TIMEOUT_CYCLES, 255, maximum consecutive ACCESS cycles with pready_i low before the transfer is aborted. 0 disables the timeout.

Ports:
clk_i  in  1  bus clock
rst_n_i  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when cmd_valid_i && cmd_ready_o
cmd_write_i  in  1  1 = write, 0 = read
cmd_addr_i  in  ADDR_WIDTH  target address
cmd_wdata_i  in  DATA_WIDTH  write data
cmd_strb_i  in  DATA_WIDTH/8  write byte strobes
cmd_prot_i  in  3  protection attributes
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_err_o  out  1  pslverr_i or timeout
rsp_tmo_o  out  1  timeout abort
paddr_o, pprot_o(3), psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o(DATA_WIDTH/8)  out  APB4 request signals
prdata_i(DATA_WIDTH), pready_i, pslverr_i  in  APB4 response signals

Behaviour:
- One clock (clk_i). Asynchronous active-low reset (rst_n_i).
- Reset state: FSM in IDLE. All registered outputs are 0: psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, rsp_rdata, rsp_err, rsp_tmo. cmd_ready_o is 1.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On handshake, register addr, write, wdata, strb and prot into the APB outputs, then go to SETUP.
  - pstrb_o is forced to 0 for reads.
  - pwdata_o takes cmd_wdata_i for both reads and writes.
- SETUP: psel_o = 1, penable_o = 0. Always go to ACCESS next cycle.
- ACCESS: psel_o = 1, penable_o = 1.
  - If pready_i = 1: latch rsp_rdata = write ? 0 : prdata_i, rsp_err = pslverr_i, rsp_tmo = 0. Go to RESP.
  - Otherwise increment the wait counter.
- Timeout (TIMEOUT_CYCLES = N > 0):
  - If pready_i is low in N consecutive ACCESS cycles, go to RESP after the Nth cycle with rsp_err = 1, rsp_tmo = 1, rsp_rdata = 0.
  - pready_i = 1 in the Nth cycle wins: normal completion.
  - The wait counter clears on entering SETUP. Its width is $clog2(N+1), minimum 1.
- RESP:
  - psel_o = 0, penable_o = 0. rsp_valid_o = 1.
  - Response data and status are held stable until rsp_ready_i, then go to IDLE.
  - cmd_ready_o = 0 in every state except IDLE.
- Stability: paddr, pwrite, pwdata, pstrb and pprot stay constant from SETUP through the end of ACCESS. They keep their last values in RESP and IDLE.
- Latency: handshake in cycle T → SETUP at T+1 → first ACCESS at T+2. With zero wait states, rsp_valid_o rises at T+3. Each wait state adds 1 cycle. Minimum command-to-command spacing is 4 cycles.
- Reset mid-transfer: outputs return immediately to reset values. The in-flight command is dropped and no response is issued.
- pslverr_i is sampled only in ACCESS when pready_i = 1. prdata_i is ignored in all other cycles.

Decomposition:
- Shared define file apb4_master_define.sv holds:
  - FSM state encodings (2-bit: IDLE = 0, SETUP = 1, ACCESS = 2, RESP = 3)
  - the PROT width constant
- Registers are built from the existing dffer/dffr primitives.
- One natural sub-module: apb4_master_tmo. It is the wait-state counter with clear, enable and an expired flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write addr 0x10, data 0xA5A5_0001, strb 0xF, pready_i = 1 → psel rises at T+1, penable at T+2, rsp_valid at T+3 with err = 0, tmo = 0, rdata = 0; pstrb_o = 0xF.
- Read addr 0x08 with pready_i held low 3 cycles, then high with prdata = 0x0000_1234 → 4 ACCESS cycles with paddr stable; rsp_rdata = 0x1234, err = 0; pstrb_o = 0.
- Read with pready_i = 1, pslverr_i = 1 → rsp_err = 1, rsp_tmo = 0, rsp_rdata = prdata_i.
- TIMEOUT_CYCLES = 4, pready_i stuck low → exactly 4 ACCESS cycles, then psel = 0 and rsp_valid with err = 1, tmo = 1. Repeat with pready_i = 1 in the 4th cycle → normal completion.
- rsp_ready_i low for 5 cycles with cmd_valid_i held high → rsp outputs stable, cmd_ready_o = 0 throughout; next command accepted one cycle after the response handshake.
- Assert rst_n_i during ACCESS → psel, penable and rsp_valid go to 0 asynchronously; after release cmd_ready_o = 1 and no stale response appears.

Source files
------------

// File: rtl/apb4_master_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb4_master_bridge_pkg
// Description : Shared types and constants for the APB4 master bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package apb4_master_bridge_pkg;

    // Width of the APB4 protection attribute field
    localparam int PROT_W = 3;

    // Bridge FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Wait counter width: enough to hold N, never narrower than one bit
    function automatic int tmo_cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb4_master_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : apb4_master_bridge_if
// Description : Command/response channels plus APB4 bus of the bridge.
//               master = bridge side, slave = requester/peripheral side.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb4_master_bridge_if
    import apb4_master_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_W = DATA_WIDTH / 8;

    // Command channel
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_write_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [DATA_WIDTH-1:0] cmd_wdata_i;
    logic [STRB_W-1:0]     cmd_strb_i;
    logic [PROT_W-1:0]     cmd_prot_i;

    // Response channel
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  rsp_tmo_o;

    // APB4 bus
    logic [ADDR_WIDTH-1:0] paddr_o;
    logic [PROT_W-1:0]     pprot_o;
    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [DATA_WIDTH-1:0] pwdata_o;
    logic [STRB_W-1:0]     pstrb_o;
    logic [DATA_WIDTH-1:0] prdata_i;
    logic                  pready_i;
    logic                  pslverr_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i, cmd_prot_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_tmo_o,
        input  rsp_ready_i,
        output paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
        input  prdata_i, pready_i, pslverr_i
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i, cmd_prot_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_tmo_o,
        output rsp_ready_i,
        input  paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
        output prdata_i, pready_i, pslverr_i
    );

endinterface
`default_nettype wire

// File: rtl/apb4_master_bridge_tmo.sv
`default_nettype none
// ============================================================================
// Module      : apb4_master_bridge_tmo
// Description : ACCESS wait-state counter with clear, enable and expired flag.
//               expired_o means N-1 waits have already been counted, so a
//               further cycle with pready low is the Nth and must abort.
// Revision    : 1.0 - initial release
// ============================================================================
module apb4_master_bridge_tmo
    import apb4_master_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire  clk_i,
    input  wire  rst_n_i,
    input  wire  clr_i,
    input  wire  en_i,
    output logic expired_o
);

    localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority over counting
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_tmo
            localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);
            assign expired_o = (cnt_q == LAST_WAIT);
        end else begin : g_no_tmo
            // Timeout disabled: the counter runs freely and is never looked at
            assign expired_o = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/apb4_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb4_master_bridge
// Description : valid/ready command to single APB4 transfer initiator with
//               wait states, slave error reporting and bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module apb4_master_bridge
    import apb4_master_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire                  clk_i,
    input  wire                  rst_n_i,
    apb4_master_bridge_if.master bus
);

    localparam int STRB_W = DATA_WIDTH / 8;

    state_e                state_q,     state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic                  pwrite_q,    pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
    logic [STRB_W-1:0]     pstrb_q,     pstrb_d;
    logic [PROT_W-1:0]     pprot_q,     pprot_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic                  rsp_tmo_q,   rsp_tmo_d;

    logic tmo_clr;
    logic tmo_en;
    logic tmo_expired;

    apb4_master_bridge_tmo #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (tmo_clr),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    // Next-state and next-output decode; every output is a flop
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pprot_d     = pprot_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_tmo_d   = rsp_tmo_q;
        tmo_clr     = 1'b0;
        tmo_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid_i && cmd_ready_q) begin
                    // Request fields are frozen here until the next command
                    paddr_d     = bus.cmd_addr_i;
                    pwrite_d    = bus.cmd_write_i;
                    pwdata_d    = bus.cmd_wdata_i;
                    pstrb_d     = bus.cmd_write_i ? bus.cmd_strb_i : '0;
                    pprot_d     = bus.cmd_prot_i;
                    psel_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                    tmo_clr     = 1'b1;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.pready_i) begin
                    // A ready slave wins even in the last allowed cycle
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata_i;
                    rsp_err_d   = bus.pslverr_i;
                    rsp_tmo_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = ST_RESP;
                end else if (tmo_expired) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_tmo_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = ST_RESP;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    assign bus.cmd_ready_o = cmd_ready_q;
    assign bus.psel_o      = psel_q;
    assign bus.penable_o   = penable_q;
    assign bus.pwrite_o    = pwrite_q;
    assign bus.paddr_o     = paddr_q;
    assign bus.pwdata_o    = pwdata_q;
    assign bus.pstrb_o     = pstrb_q;
    assign bus.pprot_o     = pprot_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_tmo_o   = rsp_tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_apb4_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb4_master_bridge
// Description : Directed vector bench for apb4_master_bridge (timeout = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb4_master_bridge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    apb4_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb4_master_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;      // ACCESS cycles with pready low before it rises
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_tmo;
        logic [3:0]  exp_pstrb;
        int          exp_acc;    // number of ACCESS cycles observed
    } vec_t;

    vec_t vecs [7];
    int   n_chk  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int acc;
        @(negedge clk);
        chk($sformatf("v%0d idle cmd_ready", idx), 32'(bus.cmd_ready_o), 32'd1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = v.write;
        bus.cmd_addr_i  = v.addr;
        bus.cmd_wdata_i = v.wdata;
        bus.cmd_strb_i  = v.strb;
        bus.cmd_prot_i  = v.prot;
        bus.pready_i    = 1'b0;
        bus.pslverr_i   = 1'b0;
        bus.prdata_i    = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        // SETUP phase, one cycle after the handshake
        chk($sformatf("v%0d setup psel", idx), 32'(bus.psel_o), 32'd1);
        chk($sformatf("v%0d setup penable", idx), 32'(bus.penable_o), 32'd0);
        chk($sformatf("v%0d setup cmd_ready", idx), 32'(bus.cmd_ready_o), 32'd0);
        chk($sformatf("v%0d paddr", idx), bus.paddr_o, v.addr);
        chk($sformatf("v%0d pwrite", idx), 32'(bus.pwrite_o), 32'(v.write));
        chk($sformatf("v%0d pwdata", idx), bus.pwdata_o, v.wdata);
        chk($sformatf("v%0d pstrb", idx), 32'(bus.pstrb_o), 32'(v.exp_pstrb));
        chk($sformatf("v%0d pprot", idx), 32'(bus.pprot_o), 32'(v.prot));
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!(bus.psel_o && bus.penable_o)) break;
            acc++;
            chk($sformatf("v%0d access%0d paddr", idx, acc), bus.paddr_o, v.addr);
            bus.pready_i  = (acc > v.waits);
            bus.pslverr_i = (acc > v.waits) ? v.slverr : 1'b0;
            bus.prdata_i  = (acc > v.waits) ? v.prdata : 32'hBAD0_BAD0;
        end
        bus.pready_i  = 1'b0;
        bus.pslverr_i = 1'b0;
        chk($sformatf("v%0d access cycles", idx), 32'(acc), 32'(v.exp_acc));
        chk($sformatf("v%0d rsp_valid", idx), 32'(bus.rsp_valid_o), 32'd1);
        chk($sformatf("v%0d resp psel", idx), 32'(bus.psel_o), 32'd0);
        chk($sformatf("v%0d rsp_rdata", idx), bus.rsp_rdata_o, v.exp_rdata);
        chk($sformatf("v%0d rsp_err", idx), 32'(bus.rsp_err_o), 32'(v.exp_err));
        chk($sformatf("v%0d rsp_tmo", idx), 32'(bus.rsp_tmo_o), 32'(v.exp_tmo));
        chk($sformatf("v%0d resp paddr held", idx), bus.paddr_o, v.addr);
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        chk($sformatf("v%0d rsp_valid dropped", idx), 32'(bus.rsp_valid_o), 32'd0);
        chk($sformatf("v%0d cmd_ready back", idx), 32'(bus.cmd_ready_o), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        wr    addr        wdata         strb  prot    waits prdata        err   exp_rdata     eerr  etmo  epstrb acc
        vecs[0] = '{1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 3'd0,   0, 32'h1111_1111, 1'b0, 32'h0,        1'b0, 1'b0, 4'hF, 1};
        vecs[1] = '{1'b0, 32'h08, 32'hDEAD_0000, 4'hF, 3'd0,   3, 32'h0000_1234, 1'b0, 32'h0000_1234, 1'b0, 1'b0, 4'h0, 4};
        vecs[2] = '{1'b0, 32'h20, 32'h0,         4'h3, 3'd2,   0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 4'h0, 1};
        vecs[3] = '{1'b0, 32'h30, 32'h0,         4'h0, 3'd0,  99, 32'hBEEF_0000, 1'b0, 32'h0,        1'b1, 1'b1, 4'h0, 4};
        vecs[4] = '{1'b0, 32'h34, 32'h0,         4'h0, 3'd4,   3, 32'h0000_55AA, 1'b0, 32'h0000_55AA, 1'b0, 1'b0, 4'h0, 4};
        vecs[5] = '{1'b1, 32'h40, 32'h0BAD_F00D, 4'h5, 3'd1,  99, 32'h0,         1'b0, 32'h0,        1'b1, 1'b1, 4'h5, 4};
        vecs[6] = '{1'b1, 32'h44, 32'h1234_5678, 4'hC, 3'd5,   1, 32'hFFFF_FFFF, 1'b1, 32'h0,        1'b1, 1'b0, 4'hC, 2};

        bus.cmd_valid_i = 1'b0;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_wdata_i = '0;
        bus.cmd_strb_i  = '0;
        bus.cmd_prot_i  = '0;
        bus.rsp_ready_i = 1'b0;
        bus.prdata_i    = '0;
        bus.pready_i    = 1'b0;
        bus.pslverr_i   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        chk("reset psel", 32'(bus.psel_o), 32'd0);
        chk("reset penable", 32'(bus.penable_o), 32'd0);
        chk("reset pwrite", 32'(bus.pwrite_o), 32'd0);
        chk("reset paddr", bus.paddr_o, 32'd0);
        chk("reset pwdata", bus.pwdata_o, 32'd0);
        chk("reset pstrb", 32'(bus.pstrb_o), 32'd0);
        chk("reset pprot", 32'(bus.pprot_o), 32'd0);
        chk("reset rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("reset rsp_rdata", bus.rsp_rdata_o, 32'd0);
        chk("reset rsp_err", 32'(bus.rsp_err_o), 32'd0);
        chk("reset rsp_tmo", 32'(bus.rsp_tmo_o), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Response back-pressure with a new command already waiting
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b1;
        bus.cmd_addr_i  = 32'h50;
        bus.cmd_wdata_i = 32'h1111_2222;
        bus.cmd_strb_i  = 4'h3;
        bus.cmd_prot_i  = 3'd2;
        bus.pready_i    = 1'b1;
        bus.prdata_i    = 32'h7777_7777;
        @(negedge clk);
        chk("bp setup psel", 32'(bus.psel_o), 32'd1);
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = 32'h60;
        @(negedge clk);
        chk("bp access penable", 32'(bus.penable_o), 32'd1);
        chk("bp access paddr stable", bus.paddr_o, 32'h50);
        @(negedge clk);
        bus.pready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d rsp_valid", k), 32'(bus.rsp_valid_o), 32'd1);
            chk($sformatf("bp%0d rsp_rdata", k), bus.rsp_rdata_o, 32'd0);
            chk($sformatf("bp%0d rsp_err", k), 32'(bus.rsp_err_o), 32'd0);
            chk($sformatf("bp%0d cmd_ready", k), 32'(bus.cmd_ready_o), 32'd0);
            chk($sformatf("bp%0d paddr held", k), bus.paddr_o, 32'h50);
            @(negedge clk);
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        chk("bp after rsp cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        chk("bp after rsp psel", 32'(bus.psel_o), 32'd0);
        chk("bp after rsp rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        bus.pready_i = 1'b1;
        bus.prdata_i = 32'h6060_6060;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        chk("bp next psel", 32'(bus.psel_o), 32'd1);
        chk("bp next paddr", bus.paddr_o, 32'h60);
        chk("bp next pwrite", 32'(bus.pwrite_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        bus.pready_i = 1'b0;
        chk("bp next rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        chk("bp next rsp_rdata", bus.rsp_rdata_o, 32'h6060_6060);
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;

        // Reset asserted in the middle of ACCESS
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = 32'h70;
        bus.pready_i    = 1'b0;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        @(negedge clk);
        chk("rst pre access penable", 32'(bus.penable_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst async psel", 32'(bus.psel_o), 32'd0);
        chk("rst async penable", 32'(bus.penable_o), 32'd0);
        chk("rst async rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst async cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        chk("rst async paddr", bus.paddr_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.pready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post rst%0d rsp_valid", k), 32'(bus.rsp_valid_o), 32'd0);
            chk($sformatf("post rst%0d psel", k), 32'(bus.psel_o), 32'd0);
            chk($sformatf("post rst%0d cmd_ready", k), 32'(bus.cmd_ready_o), 32'd1);
        end
        bus.pready_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
